desition_seq: RTL and testbench

Sequencer for the `desition` learn/compare datapath. It drives the datapath `timer` (count enable) and `register` (capture strobe) inputs from two push-buttons. In the learn phase an interval is measured and stored. In the run phase the stored interval is replayed until the datapath comparator fires, producing a `done` pulse. The block sits between the board button inputs and the `desition` instance; its outputs connect directly to that instance.

---
 rtl/desition_seq.sv | 190 +++++++++++++++++++
 tb/tb_desition_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/desition_seq.sv
// desition_seq: button-driven learn/run sequencer for the desition datapath.
// Build option: define DESITION_SEQ_AUTORUN_EN to replay the stored interval back-to-back.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   btn_learn async button; a rising edge starts or stops learning
//   btn_start async button; a rising edge starts a run
//   count_in  datapath out_timer value
//   comp      datapath comparator (count == stored)
//   timer     datapath count enable
//   register  datapath capture strobe (one cycle)
//   done      one-cycle pulse per completed run
//   fault     sticky learn-overflow flag
//   busy      high in LEARN or RUN
//   state     current state code
//   runs      completed-run counter (wraps)
module desition_seq #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_COUNT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_learn,
    input  logic             btn_start,
    input  logic [WIDTH-1:0] count_in,
    input  logic             comp,
    output logic             timer,
    output logic             register,
    output logic             done,
    output logic             fault,
    output logic             busy,
    output logic [2:0]       state,
    output logic [7:0]       runs
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEARN   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_ARMED   = 3'd4,
        S_RUN     = 3'd5,
        S_DONE    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_COUNT);

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] lsync;
    logic [SYNC_STAGES-1:0] ssync;
    logic                   lprev;
    logic                   sprev;
    logic                   le;
    logic                   se;

    // Synchronizers followed by registered rising-edge detectors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsync <= '0;
            ssync <= '0;
            lprev <= 1'b0;
            sprev <= 1'b0;
            le    <= 1'b0;
            se    <= 1'b0;
        end else begin
            lsync <= {lsync[SYNC_STAGES-2:0], btn_learn};
            ssync <= {ssync[SYNC_STAGES-2:0], btn_start};
            lprev <= lsync[SYNC_STAGES-1];
            sprev <= ssync[SYNC_STAGES-1];
            le    <= lsync[SYNC_STAGES-1] & ~lprev;
            se    <= ssync[SYNC_STAGES-1] & ~sprev;
        end
    end

`ifdef DESITION_SEQ_AUTORUN_EN
    // from_done marks a SETTLE that follows DONE (replay continues);
    // le_pend holds a learn press seen in DONE/SETTLE until SETTLE exits.
    logic from_done;
    logic le_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            from_done <= 1'b0;
            le_pend   <= 1'b0;
        end else begin
            from_done <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                le_pend <= le;
            end else if (state_q == S_SETTLE) begin
                le_pend <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            runs <= 8'd0;
        end else if (state_q == S_CAPTURE) begin
            runs <= 8'd0;
        end else if (state_q == S_DONE) begin
            runs <= runs + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (le) state_d = S_LEARN;
            end
            S_LEARN: begin
                // Overflow takes priority over a stop press.
                if (&count_in) begin
                    state_d = S_FAULT;
                end else if (le && count_in >= MIN_C) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_SETTLE;
            S_SETTLE: begin
`ifdef DESITION_SEQ_AUTORUN_EN
                if (from_done) begin
                    state_d = (le_pend | le) ? S_LEARN : S_RUN;
                end else begin
                    state_d = S_ARMED;
                end
`else
                state_d = S_ARMED;
`endif
            end
            S_ARMED: begin
                if (le) begin
                    state_d = S_LEARN;
                end else if (se) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A zero count can never be a completed interval.
                if (comp && count_in != '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_SETTLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer    = 1'b0;
        register = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            S_LEARN: begin
                timer = 1'b1;
                busy  = 1'b1;
            end
            S_RUN: begin
                // Dropping the enable on comp freezes count at stored.
                timer = ~comp;
                busy  = 1'b1;
            end
            S_CAPTURE: register = 1'b1;
            S_DONE: begin
                register = 1'b1;
                done     = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_desition_seq.sv
// tb_desition_seq: directed-random bench for desition_seq with a datapath model.
// Expected values come from press timing and interval arithmetic.
module tb_desition_seq;

    localparam int W    = 20;
    localparam int MINC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         btn_learn = 1'b0;
    logic         btn_start = 1'b0;
    logic         force_ones = 1'b0;
    logic         ovr_comp = 1'b0;
    logic [W-1:0] count_in;
    logic         comp;
    logic         timer;
    logic         register;
    logic         done;
    logic         fault;
    logic         busy;
    logic [2:0]   state;
    logic [7:0]   runs;

    logic [W-1:0] dp_cnt;
    logic [W-1:0] dp_stored;
    logic         dp_regd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    desition_seq #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .MIN_COUNT(MINC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_learn(btn_learn),
        .btn_start(btn_start),
        .count_in(count_in),
        .comp(comp),
        .timer(timer),
        .register(register),
        .done(done),
        .fault(fault),
        .busy(busy),
        .state(state),
        .runs(runs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: counter, capture register, delayed strobe clears the counter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_cnt    <= '0;
            dp_stored <= '0;
            dp_regd   <= 1'b0;
        end else begin
            dp_regd <= register;
            if (register) dp_stored <= dp_cnt;
            if (dp_regd) dp_cnt <= '0;
            else if (timer) dp_cnt <= dp_cnt + 1'b1;
        end
    end

    assign count_in = force_ones ? '1 : dp_cnt;
    assign comp     = (dp_cnt == dp_stored) | ovr_comp;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_st(input logic [2:0] s, input int max, input string tag);
        int k = 0;
        while (state !== s && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // Called at a negedge; records the press cycle, holds 2 cycles, releases.
    task automatic press(input bit l, input bit s, output int at);
        at = cyc;
        btn_learn = l;
        btn_start = s;
        tick(2);
        btn_learn = 1'b0;
        btn_start = 1'b0;
    endtask

    task automatic do_run(input int n, input int exp_runs, input string tag);
        int t, d, len, dummy;
        t = 0;
        d = 0;
        len = 0;
        press(1'b0, 1'b1, dummy);
        wait_st(3'd5, 10, {tag, "_enter"});
        while (state !== 3'd4 && len < n + 20) begin
            t += int'(timer);
            d += int'(done);
            len++;
            @(negedge clk);
        end
        check({tag, "_timer"}, t, n);
        check({tag, "_done"}, d, 1);
        check({tag, "_len"}, len, n + 3);
        check({tag, "_runs"}, 32'(runs), exp_runs);
    endtask

    initial begin
        int a, b, c, n, n2, k, bad, dummy;

        tick(3);
        check("rst_state", 32'(state), 0);
        check("rst_timer", 32'(timer), 0);
        check("rst_reg", 32'(register), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_runs", 32'(runs), 0);
        rst = 1'b1;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({state, timer, register, done, fault, busy, runs} !== '0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Learn press latency: LEARN exactly 4 edges after the press.
        a = cyc;
        btn_learn = 1'b1;
        tick(2);
        btn_learn = 1'b0;
        tick(1);
        check("lat_pre", 32'(state), 1'b0);
        tick(1);
        check("lat_learn", 32'(state), 1);
        check("learn_timer", 32'(timer), 1);
        check("learn_busy", 32'(busy), 1);

        // Stop press with count below MIN_COUNT is ignored.
        press(1'b1, 1'b0, b);
        tick(6);
        check("min_ignore", 32'(state), 1);

        n = $urandom_range(60, 140);
        tick(n - (cyc - a));
        press(1'b1, 1'b0, c);
        n = c - a;
        wait_st(3'd2, 10, "capture");
        check("cap_reg", 32'(register), 1);
        check("cap_count", 32'(count_in), n);
        tick(1);
        check("settle", 32'(state), 3);
        check("stored", 32'(dp_stored), n);
        tick(1);
        check("armed", 32'(state), 4);
        check("armed_cnt", 32'(dp_cnt), 0);

        k = $urandom_range(2, 3);
        for (int r = 0; r < k; r++) do_run(n, r + 1, "run");

        // Comparator with a zero count must not finish the run.
        ovr_comp = 1'b1;
        press(1'b0, 1'b1, dummy);
        wait_st(3'd5, 10, "cz_enter");
        tick(5);
        check("comp_zero", 32'(state), 5);
        check("cz_timer", 32'(timer), 0);
        ovr_comp = 1'b0;
        wait_st(3'd4, n + 20, "cz_armed");
        check("cz_runs", 32'(runs), k + 1);

        // Learn and start together: learn wins.
        press(1'b1, 1'b1, a);
        wait_st(3'd1, 10, "both_learn");
        n2 = $urandom_range(20, 60);
        tick(n2 - (cyc - a));
        press(1'b1, 1'b0, b);
        n2 = b - a;
        wait_st(3'd2, 10, "capture2");
        tick(1);
        check("runs_clr", 32'(runs), 0);
        check("stored2", 32'(dp_stored), n2);
        wait_st(3'd4, 5, "armed2");
        do_run(n2, 1, "run2");

        // Asynchronous reset mid-run.
        press(1'b0, 1'b1, dummy);
        wait_st(3'd5, 10, "mr_enter");
        tick(3);
        #2 rst = 1'b0;
        #1;
        check("mr_state", 32'(state), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_timer", 32'(timer), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // Learn overflow is sticky until reset.
        press(1'b1, 1'b0, dummy);
        wait_st(3'd1, 10, "f_learn");
        tick(3);
        force_ones = 1'b1;
        tick(1);
        check("f_state", 32'(state), 7);
        check("f_fault", 32'(fault), 1);
        check("f_busy", 32'(busy), 0);
        force_ones = 1'b0;
        press(1'b1, 1'b0, dummy);
        press(1'b0, 1'b1, dummy);
        tick(8);
        check("f_sticky", 32'(state), 7);
        #2 rst = 1'b0;
        #1;
        check("f_rst", 32'(state), 0);
        check("f_clr", 32'(fault), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
